instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/seq_pkg.sv | 32 +++
 rtl/instr_sequencer.sv | 151 +++++++++++++++
 tb/tb_instr_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared state encoding, opcode constants and defaults for instr_sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_READ_IR  = 3'd2,
    S_DECODE   = 3'd3,
    S_EXEC_MEM = 3'd4,
    S_HALT     = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  // Memory-operand instruction captured in DECODE and used during EXEC_MEM.
  typedef enum logic [1:0] {
    MOP_LDA,
    MOP_ADD,
    MOP_STA
  } mem_op_t;

  localparam int OP_NOP = 0;
  localparam int OP_LDA = 1;
  localparam int OP_ADD = 2;
  localparam int OP_STA = 3;
  localparam int OP_JMP = 4;
  localparam int OP_JZ  = 5;
  localparam int OP_HLT = 15;

  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int WAIT_W          = 4;

endpackage

// File: rtl/instr_sequencer.sv
// Control sequencer for a small accumulator CPU: fetch/decode/execute FSM with memory-wait timeout.
// Define SEQ_STEP_EN to gate the exit from FETCH on the step input (single-step mode).
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int OPC_W       = 4,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             step,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             mar_load,
  output logic             mar_sel_ir,
  output logic             ir_load,
  output logic             acc_load,
  output logic             alu_add,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state
);

  // The fault fires in the cycle the counter would reach MEM_TIMEOUT, so a
  // memory stall gets exactly MEM_TIMEOUT wait cycles before faulting.
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            cur;
  mem_op_t           op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fetch_go;
  logic              timeout;
  logic              dec_mem, dec_jmp, dec_jz, dec_hlt;
  mem_op_t           dec_op;

`ifdef SEQ_STEP_EN
  assign fetch_go = step;
`else
  logic unused_step;
  assign unused_step = step;
  assign fetch_go    = 1'b1;
`endif

  assign timeout = !mem_ready && (wait_cnt == LAST_WAIT);
  assign state   = cur;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    dec_mem = 1'b0;
    dec_jmp = 1'b0;
    dec_jz  = 1'b0;
    dec_hlt = 1'b0;
    dec_op  = MOP_LDA;
    case (opcode)
      OPC_W'(OP_LDA): begin dec_mem = 1'b1; dec_op = MOP_LDA; end
      OPC_W'(OP_ADD): begin dec_mem = 1'b1; dec_op = MOP_ADD; end
      OPC_W'(OP_STA): begin dec_mem = 1'b1; dec_op = MOP_STA; end
      OPC_W'(OP_JMP): dec_jmp = 1'b1;
      OPC_W'(OP_JZ):  dec_jz  = 1'b1;
      OPC_W'(OP_HLT): dec_hlt = 1'b1;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= S_IDLE;
      op_q     <= MOP_LDA;
      wait_cnt <= '0;
    end else begin
      case (cur)
        S_IDLE: if (run) cur <= S_FETCH;
        S_FETCH: begin
          if (fetch_go) begin
            cur      <= S_READ_IR;
            wait_cnt <= '0;
          end
        end
        S_READ_IR, S_EXEC_MEM: begin
          // A ready strobe in the timeout cycle still completes the access.
          if (mem_ready) begin
            cur <= (cur == S_READ_IR) ? S_DECODE : S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            if (timeout) cur <= S_FAULT;
          end
        end
        S_DECODE: begin
          if (dec_mem) begin
            cur      <= S_EXEC_MEM;
            op_q     <= dec_op;
            wait_cnt <= '0;
          end else if (dec_hlt) begin
            cur <= S_HALT;
          end else begin
            cur <= S_FETCH;
          end
        end
        S_HALT, S_FAULT: cur <= cur;
        default: cur <= S_FAULT;
      endcase
    end
  end

  // Strobes are Mealy on mem_ready/zero so a ready cycle loads without an extra wait state.
  always_comb begin
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mar_load   = 1'b0;
    mar_sel_ir = 1'b0;
    ir_load    = 1'b0;
    acc_load   = 1'b0;
    alu_add    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    case (cur)
      S_FETCH: mar_load = fetch_go;
      S_READ_IR: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
      end
      S_DECODE: begin
        if (dec_mem) begin
          mar_load   = 1'b1;
          mar_sel_ir = 1'b1;
        end
        pc_load = dec_jmp || (dec_jz && zero);
      end
      S_EXEC_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (op_q == MOP_STA);
        acc_load = mem_ready && (op_q != MOP_STA);
        alu_add  = mem_ready && (op_q == MOP_ADD);
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed cycle table, corner sequences and random programs.
`timescale 1ns/1ps
module tb_instr_sequencer;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0, zero = 1'b0, mem_ready = 1'b0, step = 1'b0;
  logic [3:0] opcode = '0;
  logic       pc_inc, pc_load, mar_load, mar_sel_ir, ir_load, acc_load, alu_add;
  logic       mem_req, mem_we, halted, fault;
  logic [2:0] state;

  instr_sequencer #(.OPC_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .step(step),
    .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load), .mar_sel_ir(mar_sel_ir),
    .ir_load(ir_load), .acc_load(acc_load), .alu_add(alu_add), .mem_req(mem_req),
    .mem_we(mem_we), .halted(halted), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // Output word order: pc_inc pc_load mar_load mar_sel_ir ir_load acc_load alu_add mem_req mem_we halted fault
  localparam logic [10:0] PCI  = 11'h400, PCL  = 11'h200, MARL = 11'h100, MSEL = 11'h080;
  localparam logic [10:0] IRL  = 11'h040, ACCL = 11'h020, ADDS = 11'h010, MREQ = 11'h008;
  localparam logic [10:0] MWE  = 11'h004, HLTD = 11'h002, FLT  = 11'h001, NONE = 11'h000;

  typedef struct packed {
    logic       run, step, zero, mem_ready;
    logic [3:0] opcode;
    logic [10:0] exp;
    logic [2:0] st;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t q[$];
  vec_t tbl[18];

  function automatic logic [10:0] outs();
    return {pc_inc, pc_load, mar_load, mar_sel_ir, ir_load, acc_load, alu_add,
            mem_req, mem_we, halted, fault};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic vec_t mk_vec(input logic r, s, z, mr, input logic [3:0] opc,
                                  input logic [10:0] e, input state_t st);
    vec_t v;
    v.run = r; v.step = s; v.zero = z; v.mem_ready = mr;
    v.opcode = opc; v.exp = e; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic apply_vec(input vec_t v, input string name);
    @(negedge clk);
    run = v.run; step = v.step; zero = v.zero; mem_ready = v.mem_ready; opcode = v.opcode;
    #1;
    check(name, {state, outs()}, {v.st, v.exp});
    check({name, "_pcx"}, 14'(pc_inc & pc_load), 14'd0);
    check({name, "_ldx"}, 14'(ir_load & acc_load), 14'd0);
  endtask

  task automatic run_trace(input string tag);
    foreach (q[i]) apply_vec(q[i], $sformatf("%s[%0d]", tag, i));
    q.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; run = 1'b0; step = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = '0;
    #1 check({tag, "_rst"}, {state, outs()}, {S_IDLE, NONE});
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: expands one instruction into its expected cycle-by-cycle trace.
  task automatic push_instr(input logic [3:0] opc, input logic z, input int dr, input int de);
    logic       is_mem;
    logic [10:0] dec, we, ld;
`ifdef SEQ_STEP_EN
    repeat ($urandom_range(0, 2)) q.push_back(mk_vec(rb(), 1'b0, rb(), rb(), opc, NONE, S_FETCH));
    q.push_back(mk_vec(rb(), 1'b1, rb(), rb(), opc, MARL, S_FETCH));
`else
    q.push_back(mk_vec(rb(), rb(), rb(), rb(), opc, MARL, S_FETCH));
`endif
    repeat (dr) q.push_back(mk_vec(rb(), rb(), rb(), 1'b0, opc, MREQ, S_READ_IR));
    q.push_back(mk_vec(rb(), rb(), rb(), 1'b1, opc, MREQ | IRL | PCI, S_READ_IR));
    is_mem = opc inside {4'd1, 4'd2, 4'd3};
    dec = is_mem ? (MARL | MSEL) : (opc == 4'd4 || (opc == 4'd5 && z)) ? PCL : NONE;
    q.push_back(mk_vec(rb(), rb(), z, rb(), opc, dec, S_DECODE));
    if (is_mem) begin
      we = (opc == 4'd3) ? MWE : NONE;
      ld = (opc == 4'd1) ? ACCL : (opc == 4'd2) ? (ACCL | ADDS) : NONE;
      repeat (de) q.push_back(mk_vec(rb(), rb(), rb(), 1'b0, opc, MREQ | we, S_EXEC_MEM));
      q.push_back(mk_vec(rb(), rb(), rb(), 1'b1, opc, MREQ | we | ld, S_EXEC_MEM));
    end else if (opc == 4'd15) begin
      repeat (20) q.push_back(mk_vec(1'b1, rb(), rb(), rb(), opc, HLTD, S_HALT));
    end
  endtask

  function automatic int rand_delay();
    return ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ADD with a 3-cycle memory delay, JZ not taken then taken, NOP loop.
    tbl[0]  = mk_vec(1, 1, 0, 0, 4'd2, NONE,              S_IDLE);
    tbl[1]  = mk_vec(0, 1, 0, 1, 4'd2, MARL,              S_FETCH);
    tbl[2]  = mk_vec(0, 1, 0, 1, 4'd2, MREQ | IRL | PCI,  S_READ_IR);
    tbl[3]  = mk_vec(0, 1, 0, 0, 4'd2, MARL | MSEL,       S_DECODE);
    tbl[4]  = mk_vec(0, 1, 0, 0, 4'd2, MREQ,              S_EXEC_MEM);
    tbl[5]  = mk_vec(0, 1, 0, 0, 4'd2, MREQ,              S_EXEC_MEM);
    tbl[6]  = mk_vec(0, 1, 0, 0, 4'd2, MREQ,              S_EXEC_MEM);
    tbl[7]  = mk_vec(0, 1, 0, 1, 4'd2, MREQ | ACCL | ADDS, S_EXEC_MEM);
    tbl[8]  = mk_vec(0, 1, 0, 0, 4'd5, MARL,              S_FETCH);
    tbl[9]  = mk_vec(0, 1, 0, 1, 4'd5, MREQ | IRL | PCI,  S_READ_IR);
    tbl[10] = mk_vec(0, 1, 0, 0, 4'd5, NONE,              S_DECODE);
    tbl[11] = mk_vec(0, 1, 0, 0, 4'd5, MARL,              S_FETCH);
    tbl[12] = mk_vec(0, 1, 1, 1, 4'd5, MREQ | IRL | PCI,  S_READ_IR);
    tbl[13] = mk_vec(0, 1, 1, 0, 4'd5, PCL,               S_DECODE);
    tbl[14] = mk_vec(0, 1, 0, 1, 4'd0, MARL,              S_FETCH);
    tbl[15] = mk_vec(0, 1, 0, 1, 4'd0, MREQ | IRL | PCI,  S_READ_IR);
    tbl[16] = mk_vec(0, 1, 0, 1, 4'd0, NONE,              S_DECODE);
    tbl[17] = mk_vec(0, 1, 0, 1, 4'd0, MARL,              S_FETCH);

    do_reset("tbl");
    for (int i = 0; i < 18; i++) apply_vec(tbl[i], $sformatf("tbl[%0d]", i));

    // Read stalled for the full timeout: FAULT, then sticky despite run and mem_ready.
    do_reset("tmo");
    q.push_back(mk_vec(1, 1, 0, 0, 4'd0, NONE, S_IDLE));
    q.push_back(mk_vec(0, 1, 0, 1, 4'd0, MARL, S_FETCH));
    repeat (15) q.push_back(mk_vec(rb(), rb(), rb(), 1'b0, 4'd0, MREQ, S_READ_IR));
    repeat (5) q.push_back(mk_vec(1, rb(), rb(), 1'b1, 4'd1, FLT, S_FAULT));
    run_trace("tmo");

    // Ready on the last allowed cycle, in both read and execute; then JMP, STA, HLT.
    do_reset("bnd");
    q.push_back(mk_vec(1, 1, 0, 0, 4'd0, NONE, S_IDLE));
    push_instr(4'd0, 1'b0, 14, 0);
    push_instr(4'd1, 1'b0, 0, 14);
    push_instr(4'd4, 1'b0, 1, 0);
    push_instr(4'd3, 1'b1, 2, 1);
    push_instr(4'd15, 1'b0, 0, 0);
    run_trace("bnd");
    do_reset("halt");

    // Asynchronous reset in the middle of a store.
    q.push_back(mk_vec(1, 1, 0, 0, 4'd3, NONE, S_IDLE));
    q.push_back(mk_vec(0, 1, 0, 0, 4'd3, MARL, S_FETCH));
    q.push_back(mk_vec(0, 1, 0, 1, 4'd3, MREQ | IRL | PCI, S_READ_IR));
    q.push_back(mk_vec(0, 1, 0, 0, 4'd3, MARL | MSEL, S_DECODE));
    q.push_back(mk_vec(0, 1, 0, 0, 4'd3, MREQ | MWE, S_EXEC_MEM));
    run_trace("sta");
    @(negedge clk);
    mem_ready = 1'b1;
    #1 check("sta_busy", {state, outs()}, {S_EXEC_MEM, MREQ | MWE});
    rst = 1'b1;
    #1 check("sta_rst", {state, outs()}, {S_IDLE, NONE});
    @(negedge clk);
    #1 check("sta_rst_hold", {state, outs()}, {S_IDLE, NONE});
    rst = 1'b0;

    // Random programs ending in HLT.
    for (int p = 0; p < 4; p++) begin
      do_reset($sformatf("rnd%0d", p));
      q.push_back(mk_vec(0, rb(), rb(), rb(), 4'd0, NONE, S_IDLE));
      q.push_back(mk_vec(0, rb(), rb(), rb(), 4'd0, NONE, S_IDLE));
      q.push_back(mk_vec(1, 1, rb(), rb(), 4'd0, NONE, S_IDLE));
      for (int n = 0; n < 25; n++)
        push_instr(4'($urandom_range(0, 14)), rb(), rand_delay(), rand_delay());
      push_instr(4'd15, rb(), rand_delay(), 0);
      run_trace($sformatf("rnd%0d", p));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
